// File: rtl/bp_update_ctrl_pkg.sv
// Shared constants for the branch-predictor update controller.
// FSM encodings, data bus width and sequential PC increment.
package bp_update_ctrl_pkg;

  localparam int DataBusBits = 64;
  localparam int PcInc = 4;

  typedef enum logic {
    BPU_INIT = 1'b0,
    BPU_RUN  = 1'b1
  } bpu_state_e;

endpackage

// File: rtl/bp_update_ctrl_sync_fifo.sv
// sync_fifo: small synchronous FIFO with wrap-bit pointers.
// Reusable by any pipeline buffer; head is the oldest entry.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PtrOne = 1;

  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic [WIDTH-1:0] mem [DEPTH];

  logic do_push;
  logic do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Pointer advance; push and pop may coincide.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + PtrOne;
      if (do_pop)  rptr <= rptr + PtrOne;
    end
  end

  // Storage write; contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty = (wptr == rptr);
  assign head  = mem[rptr[AW-1:0]];

endmodule

// File: rtl/bp_update_ctrl.sv
// Branch-predictor update controller: mispredict redirect plus
// FIFO-buffered predictor training. Option: BP_UPDATE_PERF_EN.
module bp_update_ctrl
  import bp_update_ctrl_pkg::*;
#(
  parameter int XLEN        = DataBusBits,
  parameter int DEPTH       = 4,
  parameter int INIT_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            res_valid,
  output logic            res_ready,
  input  logic [XLEN-1:0] res_pc,
  input  logic [XLEN-1:0] res_target,
  input  logic            res_taken,
  input  logic [XLEN-1:0] res_pred_pc,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            bp_we,
  output logic [XLEN-1:0] bp_pc,
  output logic [XLEN-1:0] bp_target,
  output logic            bp_taken,
`ifdef BP_UPDATE_PERF_EN
  output logic [31:0]     perf_branches,
  output logic [31:0]     perf_mispredicts,
`endif
  output logic            busy
);

  localparam int EW = 2 * XLEN + 1;
  localparam int CW = $clog2(INIT_CYCLES) + 1;
  localparam logic [CW-1:0] CntLast = CW'(INIT_CYCLES - 1);
  localparam logic [CW-1:0] CntOne  = 1;

  bpu_state_e state;
  bpu_state_e state_nxt;
  logic [CW-1:0] cnt;

  logic in_init;
  logic drain_en;

  logic          accept;
  logic          mispredict;
  logic [XLEN-1:0] next_pc;

  logic          f_full;
  logic          f_empty;
  logic          f_pop;
  logic [EW-1:0] f_wdata;
  logic [EW-1:0] f_head;

  assign res_ready = ~f_full;
  assign accept    = res_valid & res_ready;

  assign next_pc = res_taken ? res_target
                             : res_pc + XLEN'(PcInc);

  assign mispredict = accept & (next_pc != res_pred_pc);

  assign f_wdata = {res_pc, res_target, res_taken};
  assign f_pop   = drain_en & ~f_empty;

  sync_fifo #(
    .WIDTH(EW),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (accept),
    .pop  (f_pop),
    .wdata(f_wdata),
    .full (f_full),
    .empty(f_empty),
    .head (f_head)
  );

  // State register and INIT cycle counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= BPU_INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == BPU_INIT) cnt <= cnt + CntOne;
    end
  end

  // Next state: leave INIT once the tables have had time to clear.
  always_comb begin
    state_nxt = state;
    unique case (state)
      BPU_INIT: if (cnt == CntLast) state_nxt = BPU_RUN;
      BPU_RUN:  state_nxt = BPU_RUN;
      default:  state_nxt = BPU_INIT;
    endcase
  end

  // State decode: draining is only allowed in RUN.
  always_comb begin
    in_init  = 1'b0;
    drain_en = 1'b0;
    unique case (state)
      BPU_INIT: in_init  = 1'b1;
      BPU_RUN:  drain_en = 1'b1;
      default:  in_init  = 1'b1;
    endcase
  end

  // One-cycle redirect pulse; the PC holds between pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      redirect_valid <= mispredict;
      if (mispredict) redirect_pc <= next_pc;
    end
  end

  // Registered predictor write of the popped FIFO head.
  always_ff @(posedge clk) begin
    if (reset) begin
      bp_we     <= 1'b0;
      bp_pc     <= '0;
      bp_target <= '0;
      bp_taken  <= 1'b0;
    end else begin
      bp_we <= f_pop;
      if (f_pop) begin
        bp_pc     <= f_head[EW-1 -: XLEN];
        bp_target <= f_head[XLEN:1];
        bp_taken  <= f_head[0];
      end
    end
  end

`ifdef BP_UPDATE_PERF_EN
  // Free-running event counters, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_branches    <= '0;
      perf_mispredicts <= '0;
    end else begin
      if (accept)     perf_branches    <= perf_branches + 32'd1;
      if (mispredict) perf_mispredicts <= perf_mispredicts + 32'd1;
    end
  end
`endif

  assign busy = in_init | ~f_empty | bp_we;

endmodule

// File: tb/tb_bp_update_ctrl.sv
// Randomized bench for bp_update_ctrl against a queue-based model.
// Define BP_UPDATE_PERF_EN to also check the perf counters.
module tb_bp_update_ctrl;

  localparam int XLEN  = 64;
  localparam int DEPTH = 4;
  localparam int INITC = 2;
  localparam int NCYC  = 3000;

  typedef struct {
    logic [63:0] pc;
    logic [63:0] tgt;
    logic        tk;
  } upd_t;

  logic            clk;
  logic            reset;
  logic            res_valid;
  logic            res_ready;
  logic [XLEN-1:0] res_pc;
  logic [XLEN-1:0] res_target;
  logic            res_taken;
  logic [XLEN-1:0] res_pred_pc;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            bp_we;
  logic [XLEN-1:0] bp_pc;
  logic [XLEN-1:0] bp_target;
  logic            bp_taken;
  logic            busy;
`ifdef BP_UPDATE_PERF_EN
  logic [31:0]     perf_branches;
  logic [31:0]     perf_mispredicts;
`endif

  bp_update_ctrl #(
    .XLEN(XLEN),
    .DEPTH(DEPTH),
    .INIT_CYCLES(INITC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_pc        (res_pc),
    .res_target    (res_target),
    .res_taken     (res_taken),
    .res_pred_pc   (res_pred_pc),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .bp_we         (bp_we),
    .bp_pc         (bp_pc),
    .bp_target     (bp_target),
    .bp_taken      (bp_taken),
`ifdef BP_UPDATE_PERF_EN
    .perf_branches   (perf_branches),
    .perf_mispredicts(perf_mispredicts),
`endif
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h @%0t",
               tag, obs, exp, $time);
    end
  endtask

  // Reference model: queued updates, cycles since reset,
  // and what each registered output should show now.
  upd_t        q[$];
  int          k;
  logic        e_rv;
  logic [63:0] e_rpc;
  logic        e_we;
  upd_t        e_bp;
  int unsigned e_br;
  int unsigned e_mis;

  task automatic model_reset();
    q.delete();
    k      = 0;
    e_rv   = 1'b0;
    e_rpc  = '0;
    e_we   = 1'b0;
    e_bp   = '{pc: '0, tgt: '0, tk: 1'b0};
    e_br   = 0;
    e_mis  = 0;
  endtask

  task automatic model_step();
    logic        acc;
    logic        mis;
    logic        pop;
    logic [63:0] npc;
    upd_t        u;
    acc = res_valid && (q.size() < DEPTH);
    npc = res_taken ? res_target : res_pc + 64'd4;
    mis = acc && (npc != res_pred_pc);
    pop = (k >= INITC) && (q.size() > 0);
    e_rv = mis;
    if (mis) e_rpc = npc;
    e_we = pop;
    if (pop) e_bp = q.pop_front();
    if (acc) begin
      u.pc  = res_pc;
      u.tgt = res_target;
      u.tk  = res_taken;
      q.push_back(u);
      e_br++;
    end
    if (mis) e_mis++;
    if (k < 1000) k++;
  endtask

  task automatic check_now();
    logic eb;
    eb = (k < INITC) || (q.size() > 0) || e_we;
    chk("ready", 64'(res_ready), 64'(q.size() < DEPTH));
    chk("busy",  64'(busy), 64'(eb));
    chk("rdr_v", 64'(redirect_valid), 64'(e_rv));
    chk("rdr_pc", redirect_pc, e_rpc);
    chk("bp_we", 64'(bp_we), 64'(e_we));
    chk("bp_pc", bp_pc, e_bp.pc);
    chk("bp_tgt", bp_target, e_bp.tgt);
    chk("bp_tk", 64'(bp_taken), 64'(e_bp.tk));
`ifdef BP_UPDATE_PERF_EN
    chk("perf_br", 64'(perf_branches), 64'(e_br));
    chk("perf_mis", 64'(perf_mispredicts), 64'(e_mis));
`endif
  endtask

  task automatic rand_resolve(input int vprob);
    logic [63:0] npc;
    res_valid = ($urandom_range(99) < vprob);
    res_pc    = 64'($urandom_range(16'hffff)) << 2;
    if ($urandom_range(19) == 0) res_pc = 64'hffff_ffff_ffff_fffc;
    res_target = {32'($urandom), 32'($urandom)} & 64'hffff_fffc;
    res_taken  = $urandom_range(1);
    npc = res_taken ? res_target : res_pc + 64'd4;
    res_pred_pc = ($urandom_range(1) == 1) ? npc
                : {32'($urandom), 32'($urandom)};
  endtask

  int vprob;

  initial begin
    reset       = 1'b1;
    res_valid   = 1'b0;
    res_pc      = '0;
    res_target  = '0;
    res_taken   = 1'b0;
    res_pred_pc = '0;
    model_reset();
    for (int n = 0; n < NCYC; n++) begin
      @(negedge clk);
      check_now();
      unique case ((n / 200) % 3)
        0: vprob = 100;
        1: vprob = 70;
        default: vprob = 30;
      endcase
      if (n < 20) vprob = 100;
      rand_resolve(vprob);
      reset = (n > 20) && ($urandom_range(149) == 0);
      if (reset) model_reset();
      else model_step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
